// File: rtl/rob_commit_rat.sv
// rob_commit_rat: register alias table plus architectural register file.
// Dispatch allocates producer tags per rd and looks up sources through
// rs1/rs2 (committed value, or the ROB tag of the pending producer).
// The in-order commit stream retires values into the architectural file.
// commit_ptr_o tracks the ROB head; retired_cnt_o counts commits.
module rob_commit_rat #(
    parameter int NUM_REGS  = 32,
    parameter int ROB_IDX_W = 5,
    parameter int XLEN      = 32
) (
    input  logic                 clk_i,
    input  logic                 reset_i,
    input  logic                 alloc_valid_i,
    input  logic [4:0]           alloc_rd_addr_i,
    input  logic [ROB_IDX_W-1:0] alloc_rob_idx_i,
    input  logic [4:0]           rs1_addr_i,
    input  logic [4:0]           rs2_addr_i,
    output logic                 rs1_busy_o,
    output logic                 rs2_busy_o,
    output logic [ROB_IDX_W-1:0] rs1_rob_idx_o,
    output logic [ROB_IDX_W-1:0] rs2_rob_idx_o,
    output logic [XLEN-1:0]      rs1_value_o,
    output logic [XLEN-1:0]      rs2_value_o,
    input  logic                 commit_valid_i,
    input  logic [4:0]           commit_rd_addr_i,
    input  logic [XLEN-1:0]      commit_value_i,
    output logic [ROB_IDX_W-1:0] commit_ptr_o,
    output logic [31:0]          retired_cnt_o
);

    localparam int LW = 1 + ROB_IDX_W + XLEN;

    logic [XLEN-1:0]      arf_q [NUM_REGS];
    logic [ROB_IDX_W-1:0] tag_q [NUM_REGS];
    logic [NUM_REGS-1:0]  busy_q;
    logic [ROB_IDX_W-1:0] commit_ptr_q;
    logic [31:0]          retired_cnt_q;

    logic alloc_en;
    logic commit_en;
    logic alloc_hits_commit;
    logic commit_clears;

    assign alloc_en  = alloc_valid_i && (alloc_rd_addr_i != 5'd0);
    assign commit_en = commit_valid_i && (commit_rd_addr_i != 5'd0);
    // A same-cycle allocate to the committed rd keeps the new mapping.
    assign alloc_hits_commit = alloc_en && (alloc_rd_addr_i == commit_rd_addr_i);
    // Only the youngest producer's commit may clear busy.
    assign commit_clears = commit_en && busy_q[commit_rd_addr_i]
                        && (tag_q[commit_rd_addr_i] == commit_ptr_q)
                        && !alloc_hits_commit;

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                arf_q[i] <= '0;
                tag_q[i] <= '0;
            end
            busy_q        <= '0;
            commit_ptr_q  <= '0;
            retired_cnt_q <= '0;
        end else begin
            if (commit_valid_i) begin
                commit_ptr_q  <= commit_ptr_q + 1'b1;
                retired_cnt_q <= retired_cnt_q + 32'd1;
            end
            if (commit_en) begin
                arf_q[commit_rd_addr_i] <= commit_value_i;
            end
            if (commit_clears) begin
                busy_q[commit_rd_addr_i] <= 1'b0;
            end
            if (alloc_en) begin
                busy_q[alloc_rd_addr_i] <= 1'b1;
                tag_q[alloc_rd_addr_i]  <= alloc_rob_idx_i;
            end
        end
    end

    // Packed result: {busy, tag, value}. The commit bypass forwards the
    // value retiring this cycle when it belongs to the current producer.
    function automatic logic [LW-1:0] lookup(input logic [4:0] rs);
        logic [LW-1:0] r;
        r = '0;
        if (rs != 5'd0) begin
            if (busy_q[rs] && commit_valid_i && (tag_q[rs] == commit_ptr_q)
                && (commit_rd_addr_i == rs)) begin
                r = {1'b0, {ROB_IDX_W{1'b0}}, commit_value_i};
            end else if (busy_q[rs]) begin
                r = {1'b1, tag_q[rs], {XLEN{1'b0}}};
            end else begin
                r = {1'b0, {ROB_IDX_W{1'b0}}, arf_q[rs]};
            end
        end
        return r;
    endfunction

    logic [LW-1:0] lk1;
    logic [LW-1:0] lk2;

    always_comb begin
        lk1 = '0;
        lk2 = '0;
        if (!reset_i) begin
            lk1 = lookup(rs1_addr_i);
            lk2 = lookup(rs2_addr_i);
        end
    end

    assign {rs1_busy_o, rs1_rob_idx_o, rs1_value_o} = lk1;
    assign {rs2_busy_o, rs2_rob_idx_o, rs2_value_o} = lk2;
    assign commit_ptr_o  = commit_ptr_q;
    assign retired_cnt_o = retired_cnt_q;

endmodule
